// File: rtl/counter_xn_pkg.sv
// Shared encodings for the N-channel programmable timer/counter.
// Register selects, channel modes and CTRL bit positions live here.
package counter_xn_pkg;

   typedef enum logic [1:0] {
      REG_COUNT  = 2'b00,
      REG_LOAD   = 2'b01,
      REG_CTRL   = 2'b10,
      REG_STATUS = 2'b11
   } reg_sel_e;

   // Encoding 2'b11 is not listed and behaves as one-shot.
   typedef enum logic [1:0] {
      MODE_ONESHOT  = 2'b00,
      MODE_PERIODIC = 2'b01,
      MODE_SQUARE   = 2'b10
   } mode_e;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_MODE_MSB = 2;
   localparam int CTRL_IE       = 3;
   localparam int CTRL_PRE_LSB  = 8;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/counter_xn_if.sv
// MIO-side register bus plus the per-channel outputs and interrupt line.
// The CPU drives the master modport; the counter block sits on the slave modport.
interface counter_xn_if #(
   parameter int N_CH = 4
);
   import counter_xn_pkg::*;

   localparam int CH_W = ch_width(N_CH);

   logic            counter_we;
   logic [CH_W-1:0] counter_ch;
   logic [1:0]      reg_sel;
   logic [31:0]     counter_val;
   logic [31:0]     counter_out;
   logic [N_CH-1:0] ch_out;
   logic            irq;

   modport master (
      output counter_we,
      output counter_ch,
      output reg_sel,
      output counter_val,
      input  counter_out,
      input  ch_out,
      input  irq
   );

   modport slave (
      input  counter_we,
      input  counter_ch,
      input  reg_sel,
      input  counter_val,
      output counter_out,
      output ch_out,
      output irq
   );

endinterface

// File: rtl/counter_xn_ch.sv
// One timer channel: prescaler, down-counting COUNT with LOAD reload,
// CTRL fields, sticky pending flag and the channel output level/pulse.
module counter_xn_ch
   import counter_xn_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int PRE_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [1:0]       reg_sel_i,
   input  logic [31:0]      wdata_i,
   output logic [CNT_W-1:0] count_o,
   output logic [CNT_W-1:0] load_o,
   output logic [31:0]      ctrl_o,
   output logic             pending_o,
   output logic             ch_out_o,
   output logic             irq_req_o
);

   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] load_q, load_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [PRE_W-1:0] presc_q, presc_d;
   logic [1:0]       mode_q, mode_d;
   logic             en_q, en_d;
   logic             ie_q, ie_d;
   logic             pending_q, pending_d;
   logic             ch_out_q, ch_out_d;

   logic run, tick, reloads;
   logic wr_count, wr_load, wr_ctrl, wr_status, wr_block;
   logic unused_wdata;

   assign unused_wdata = ^wdata_i;

   assign wr_count  = wr_en_i && (reg_sel_i == REG_COUNT);
   assign wr_load   = wr_en_i && (reg_sel_i == REG_LOAD);
   assign wr_ctrl   = wr_en_i && (reg_sel_i == REG_CTRL);
   assign wr_status = wr_en_i && (reg_sel_i == REG_STATUS);
   // A STATUS clear does not suppress a coinciding event; every other write does.
   assign wr_block  = wr_count || wr_load || wr_ctrl;

   assign run     = en_q && (load_q != '0);
   assign tick    = run && (presc_q == pre_q);
   assign reloads = (mode_q == MODE_PERIODIC) || (mode_q == MODE_SQUARE);

   always_comb begin
      count_d   = count_q;
      load_d    = load_q;
      pre_d     = pre_q;
      presc_d   = presc_q;
      mode_d    = mode_q;
      en_d      = en_q;
      ie_d      = ie_q;
      pending_d = pending_q;
      ch_out_d  = (mode_q == MODE_PERIODIC) ? 1'b0 : ch_out_q;

      if (run) begin
         presc_d = tick ? '0 : presc_q + PRE_W'(1);
      end

      if (wr_status && wdata_i[0]) begin
         pending_d = 1'b0;
      end

      if (tick && !wr_block) begin
         if (count_q == CNT_W'(1)) begin
            pending_d = 1'b1;
            if (reloads) begin
               count_d  = load_q;
               ch_out_d = (mode_q == MODE_SQUARE) ? ~ch_out_q : 1'b1;
            end else begin
               count_d  = '0;
               en_d     = 1'b0;
               ch_out_d = 1'b1;
            end
         end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
         end else if (reloads) begin
            count_d = load_q;
         end
      end

      if (wr_count) begin
         count_d = wdata_i[CNT_W-1:0];
      end

      if (wr_load) begin
         load_d    = wdata_i[CNT_W-1:0];
         count_d   = wdata_i[CNT_W-1:0];
         presc_d   = '0;
         pending_d = 1'b0;
         if (mode_q != MODE_SQUARE) begin
            ch_out_d = 1'b0;
         end
      end

      if (wr_ctrl) begin
         en_d    = wdata_i[CTRL_EN];
         mode_d  = wdata_i[CTRL_MODE_MSB:CTRL_MODE_LSB];
         ie_d    = wdata_i[CTRL_IE];
         pre_d   = wdata_i[CTRL_PRE_LSB +: PRE_W];
         presc_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= '0;
         load_q    <= '0;
         pre_q     <= '0;
         presc_q   <= '0;
         mode_q    <= '0;
         en_q      <= 1'b0;
         ie_q      <= 1'b0;
         pending_q <= 1'b0;
         ch_out_q  <= 1'b0;
      end else begin
         count_q   <= count_d;
         load_q    <= load_d;
         pre_q     <= pre_d;
         presc_q   <= presc_d;
         mode_q    <= mode_d;
         en_q      <= en_d;
         ie_q      <= ie_d;
         pending_q <= pending_d;
         ch_out_q  <= ch_out_d;
      end
   end

   assign count_o   = count_q;
   assign load_o    = load_q;
   assign ctrl_o    = 32'({pre_q, 4'b0000, ie_q, mode_q, en_q});
   assign pending_o = pending_q;
   assign ch_out_o  = ch_out_q;
   assign irq_req_o = pending_q & ie_q;

endmodule

// File: rtl/counter_xn.sv
// N-channel timer/counter on the MIO bus: channel write decode, register
// read mux and the registered interrupt reduction around N_CH channel instances.
module counter_xn
   import counter_xn_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CNT_W = 32,
   parameter int PRE_W = 8
) (
   input logic         clk,
   input logic         rst,
   counter_xn_if.slave bus
);

   localparam int CH_W = ch_width(N_CH);

   logic [N_CH-1:0]  wr_en;
   logic [N_CH-1:0]  pending;
   logic [N_CH-1:0]  ch_out;
   logic [N_CH-1:0]  irq_req;
   logic [CNT_W-1:0] count [N_CH];
   logic [CNT_W-1:0] load  [N_CH];
   logic [31:0]      ctrl  [N_CH];
   logic [31:0]      rdata;
   logic             irq_q;

   // Channel indices past N_CH match no slot, so their writes drop and reads return 0.
   always_comb begin
      wr_en = '0;
      for (int i = 0; i < N_CH; i++) begin
         wr_en[i] = bus.counter_we && (bus.counter_ch == CH_W'(i));
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      counter_xn_ch #(
         .CNT_W (CNT_W),
         .PRE_W (PRE_W)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .wr_en_i   (wr_en[g]),
         .reg_sel_i (bus.reg_sel),
         .wdata_i   (bus.counter_val),
         .count_o   (count[g]),
         .load_o    (load[g]),
         .ctrl_o    (ctrl[g]),
         .pending_o (pending[g]),
         .ch_out_o  (ch_out[g]),
         .irq_req_o (irq_req[g])
      );
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (bus.counter_ch == CH_W'(i)) begin
            case (bus.reg_sel)
               REG_COUNT:  rdata = 32'(count[i]);
               REG_LOAD:   rdata = 32'(load[i]);
               REG_CTRL:   rdata = ctrl[i];
               REG_STATUS: rdata = {30'b0, ch_out[i], pending[i]};
               default:    rdata = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |irq_req;
      end
   end

   assign bus.counter_out = rdata;
   assign bus.ch_out      = ch_out;
   assign bus.irq         = irq_q;

endmodule
